// File: rtl/stack_sequencer.sv
// stack_sequencer: bounds-checked 1-3 byte push/pull sequencer driving SP strobes and page-1 memory accesses
module stack_sequencer #(
  parameter logic [7:0] STACK_PAGE = 8'h01,
  parameter bit CHECK_BOUNDS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op_pull,
  input  logic [1:0]  op_len,
  input  logic [23:0] push_data,
  input  logic [7:0]  sp,
  output logic        push,
  output logic        pop,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic [23:0] pull_data,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, PUSH, PULL_INC, PULL_RD, PULL_CAP, DONE} state_t;
  state_t state, next;
  logic [1:0] n, k, wsel, cidx;
  logic [23:0] data;
  logic err_q, bad, last;
  assign bad = (op_len == 2'd0) || (CHECK_BOUNDS && (op_pull ? (sp > 8'hFF - {6'd0, op_len}) : (sp < {6'd0, op_len})));
  assign last = (k == n - 2'd1);
  assign wsel = n - 2'd1 - k;
  assign cidx = k - 2'd1;
  // state register; reset aborts any command in flight
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  // next-state: rejected requests go straight to DONE without touching SP or memory
  always_comb begin
    next = state;
    case (state)
      IDLE:     if (start) next = bad ? DONE : (op_pull ? PULL_INC : PUSH);
      PUSH:     if (last) next = DONE;
      PULL_INC: next = PULL_RD;
      PULL_RD:  if (last) next = PULL_CAP;
      PULL_CAP: next = DONE;
      default:  next = IDLE;
    endcase
  end
  // strobes and address are decoded from state so reset silences them at once
  always_comb begin
    push = state == PUSH;
    pop = (state == PULL_INC) || (state == PULL_RD && !last);
    mem_we = state == PUSH;
    mem_re = state == PULL_RD;
    mem_addr = (mem_we || mem_re) ? {STACK_PAGE, sp} : 16'h0000;
    mem_wdata = mem_we ? data[{wsel, 3'b000} +: 8] : 8'h00;
    busy = state != IDLE;
    done = state == DONE;
    err = done && err_q;
  end
  // command latch, byte index and pull capture; read k-1 lands while read k is issued
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      n <= 2'd0;
      k <= 2'd0;
      data <= 24'h0;
      err_q <= 1'b0;
      pull_data <= 24'h0;
    end else if (state == IDLE && start) begin
      n <= op_len;
      k <= 2'd0;
      data <= push_data;
      err_q <= bad;
      pull_data <= 24'h0;
    end else begin
      if (state == PUSH || state == PULL_RD) k <= k + 2'd1;
      if ((state == PULL_RD && k != 2'd0) || state == PULL_CAP) pull_data[{cidx, 3'b000} +: 8] <= mem_rdata;
    end
endmodule
